// File: rtl/lsu_mem_port.sv
// lsu_mem_port: load/store initiator for the 64-bit data memory port.
// Stores go out as byte writes; loads use one or two 64-bit reads.
module lsu_mem_port #(
    parameter int DM_ADDR_BITS = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_op,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    output logic [63:0] resp_rdata,
    output logic        resp_err,
    output logic [2:0]  dm_rd_ctrl,
    output logic [2:0]  dm_wr_ctrl,
    output logic [63:0] dm_addr,
    output logic [63:0] dm_din,
    input  logic [63:0] dm_dout
);

    typedef enum logic [2:0] {
        IDLE,
        RD0,
        RD1,
        WR,
        RESP
    } state_t;

    localparam logic [2:0] CTRL_LD   = 3'b101;
    localparam logic [2:0] CTRL_SB   = 3'b001;
    localparam logic [2:0] CTRL_IDLE = 3'b000;

    state_t      state;
    logic [2:0]  op_q;
    logic [63:0] addr_q;
    logic [63:0] wdata_q;
    logic [63:0] lo_q;
    logic [2:0]  idx_q;

    logic [3:0]  req_size;
    logic [64:0] req_end;
    logic        req_err;
    logic [3:0]  cur_size;
    logic        crosses;
    logic [6:0]  hi_shamt;
    logic [63:0] combined;
    logic [2:0]  idx_next;
    logic        last_byte;
    logic [63:0] hi_addr;

    function automatic logic [3:0] size_of(input logic [1:0] sz);
        return 4'd1 << sz;
    endfunction

    function automatic logic [63:0] extend(
        input logic [2:0]  op,
        input logic [63:0] d
    );
        logic [63:0] r;
        r = d;
        case (op[1:0])
            2'b00:   r = op[2] ? {56'd0, d[7:0]}  : {{56{d[7]}}, d[7:0]};
            2'b01:   r = op[2] ? {48'd0, d[15:0]} : {{48{d[15]}}, d[15:0]};
            2'b10:   r = op[2] ? {32'd0, d[31:0]} : {{32{d[31]}}, d[31:0]};
            default: r = d;
        endcase
        return r;
    endfunction

    // Request checks and per-state address/data helpers.
    always_comb begin
        req_size  = size_of(req_op[1:0]);
        // 65-bit sum so a wrap past 2^64 lands in the error range.
        req_end   = {1'b0, req_addr} + {61'd0, req_size} - 65'd1;
        req_err   = (|req_end[64:DM_ADDR_BITS])
                  || (req_we && req_op[2])
                  || (req_op == 3'b111);
        cur_size  = size_of(op_q[1:0]);
        crosses   = ({1'b0, addr_q[2:0]} + cur_size) > 4'd8;
        // The first read returns 8-addr[2:0] valid bytes; hi sits above them.
        hi_shamt  = 7'd64 - {1'b0, addr_q[2:0], 3'b000};
        combined  = lo_q | (dm_dout << hi_shamt);
        idx_next  = idx_q + 3'd1;
        last_byte = ({1'b0, idx_q} == (cur_size - 4'd1));
        hi_addr   = (addr_q | 64'd7) + 64'd1;
    end

    // Control FSM with registered handshake and memory-port outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            op_q       <= 3'd0;
            addr_q     <= 64'd0;
            wdata_q    <= 64'd0;
            lo_q       <= 64'd0;
            idx_q      <= 3'd0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= 64'd0;
            dm_rd_ctrl <= CTRL_IDLE;
            dm_wr_ctrl <= CTRL_IDLE;
            dm_addr    <= 64'd0;
            dm_din     <= 64'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        op_q      <= req_op;
                        addr_q    <= req_addr;
                        wdata_q   <= req_wdata;
                        idx_q     <= 3'd0;
                        req_ready <= 1'b0;
                        if (req_err) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= 64'd0;
                        end else if (req_we) begin
                            state      <= WR;
                            dm_wr_ctrl <= CTRL_SB;
                            dm_addr    <= req_addr;
                            dm_din     <= {8{req_wdata[7:0]}};
                        end else begin
                            state      <= RD0;
                            dm_rd_ctrl <= CTRL_LD;
                            dm_addr    <= req_addr;
                        end
                    end
                end
                RD0: begin
                    lo_q <= dm_dout;
                    if (crosses) begin
                        state   <= RD1;
                        dm_addr <= hi_addr;
                    end else begin
                        state      <= RESP;
                        dm_rd_ctrl <= CTRL_IDLE;
                        dm_addr    <= 64'd0;
                        resp_valid <= 1'b1;
                        resp_rdata <= extend(op_q, dm_dout);
                    end
                end
                RD1: begin
                    state      <= RESP;
                    dm_rd_ctrl <= CTRL_IDLE;
                    dm_addr    <= 64'd0;
                    resp_valid <= 1'b1;
                    resp_rdata <= extend(op_q, combined);
                end
                WR: begin
                    if (last_byte) begin
                        state      <= RESP;
                        dm_wr_ctrl <= CTRL_IDLE;
                        dm_addr    <= 64'd0;
                        dm_din     <= 64'd0;
                        resp_valid <= 1'b1;
                        resp_rdata <= 64'd0;
                    end else begin
                        idx_q   <= idx_next;
                        dm_addr <= addr_q + {61'd0, idx_next};
                        dm_din  <= {8{wdata_q[{idx_next, 3'b000} +: 8]}};
                    end
                end
                RESP: begin
                    state      <= IDLE;
                    req_ready  <= 1'b1;
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                    resp_rdata <= 64'd0;
                end
                default: begin
                    state      <= IDLE;
                    req_ready  <= 1'b1;
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                    resp_rdata <= 64'd0;
                    dm_rd_ctrl <= CTRL_IDLE;
                    dm_wr_ctrl <= CTRL_IDLE;
                    dm_addr    <= 64'd0;
                    dm_din     <= 64'd0;
                end
            endcase
        end
    end

endmodule
